elevator_controller: RTL and testbench

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

---
 rtl/elevator_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_elevator_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
// Module      : elevator_controller
// Description : Three-floor elevator car controller. It picks a target floor
//               from the pending request vector using a direction-preference
//               sweep. It then travels one floor every TRAVEL_CYCLES clocks
//               and holds the door open for DOOR_CYCLES clocks on arrival.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_controller #(
    parameter logic [1:0] labelF1       = 2'b00,
    parameter logic [1:0] labelF2       = 2'b01,
    parameter logic [1:0] labelF3       = 2'b10,
    parameter int         TRAVEL_CYCLES = 4,
    parameter int         DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic       moving,
    output logic [1:0] goal_floor,
    output logic [1:0] current_floor,
    output logic       door_open
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

    // Floors are tracked internally as indices 0..2. The label registers hold
    // the externally visible codes, so the outputs come straight from flops.
    state_t        state_q, state_d;
    logic          dir_q, dir_d;           // 1 = up
    logic [1:0]    pos_q, pos_d;
    logic [1:0]    gidx_q, gidx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          moving_q, moving_d;
    logic          door_q, door_d;
    logic [1:0]    cur_lbl_q, cur_lbl_d;
    logic [1:0]    goal_lbl_q, goal_lbl_d;

    logic          up_hit, dn_hit;
    logic [1:0]    up_idx, dn_idx;
    logic [1:0]    sel_idx;
    logic          sel_dir;
    logic [1:0]    step_idx;

    function automatic logic [1:0] lbl(input logic [1:0] idx);
        case (idx)
            2'd0:    lbl = labelF1;
            2'd1:    lbl = labelF2;
            default: lbl = labelF3;
        endcase
    endfunction

    // Nearest request strictly above and strictly below the current floor.
    always_comb begin
        up_hit = 1'b0;
        up_idx = pos_q;
        dn_hit = 1'b0;
        dn_idx = pos_q;
        if (pos_q == 2'd0) begin
            if (req[1]) begin
                up_hit = 1'b1;
                up_idx = 2'd1;
            end else if (req[2]) begin
                up_hit = 1'b1;
                up_idx = 2'd2;
            end
        end else if (pos_q == 2'd1) begin
            if (req[2]) begin
                up_hit = 1'b1;
                up_idx = 2'd2;
            end
            if (req[0]) begin
                dn_hit = 1'b1;
                dn_idx = 2'd0;
            end
        end else begin
            if (req[1]) begin
                dn_hit = 1'b1;
                dn_idx = 2'd1;
            end else if (req[0]) begin
                dn_hit = 1'b1;
                dn_idx = 2'd0;
            end
        end
    end

    // Target choice: current floor first, then keep direction, else reverse.
    always_comb begin
        sel_idx = pos_q;
        sel_dir = dir_q;
        if (req[pos_q]) begin
            sel_idx = pos_q;
        end else if (dir_q) begin
            if (up_hit) begin
                sel_idx = up_idx;
            end else begin
                sel_idx = dn_idx;
                sel_dir = 1'b0;
            end
        end else begin
            if (dn_hit) begin
                sel_idx = dn_idx;
            end else begin
                sel_idx = up_idx;
                sel_dir = 1'b1;
            end
        end
    end

    // One-floor step toward the goal, saturating at the end floors.
    always_comb begin
        step_idx = pos_q;
        if (gidx_q > pos_q) begin
            step_idx = (pos_q == 2'd2) ? 2'd2 : pos_q + 2'd1;
        end else if (gidx_q < pos_q) begin
            step_idx = (pos_q == 2'd0) ? 2'd0 : pos_q - 2'd1;
        end
    end

    // Next-state and registered-output logic for the IDLE/MOVE/DOOR machine.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pos_d      = pos_q;
        gidx_d     = gidx_q;
        tcnt_d     = tcnt_q;
        dcnt_d     = dcnt_q;
        moving_d   = moving_q;
        door_d     = door_q;
        cur_lbl_d  = cur_lbl_q;
        goal_lbl_d = goal_lbl_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d    = MOVE;
                    moving_d   = 1'b1;
                    gidx_d     = sel_idx;
                    goal_lbl_d = lbl(sel_idx);
                    dir_d      = sel_dir;
                    tcnt_d     = '0;
                end
            end
            MOVE: begin
                if (pos_q == gidx_q) begin
                    // Already at the goal: a single-cycle zero-travel move.
                    state_d  = DOOR;
                    moving_d = 1'b0;
                    door_d   = 1'b1;
                    dcnt_d   = '0;
                end else if (tcnt_q == T_LAST) begin
                    tcnt_d    = '0;
                    pos_d     = step_idx;
                    cur_lbl_d = lbl(step_idx);
                    if (step_idx == gidx_q) begin
                        state_d  = DOOR;
                        moving_d = 1'b0;
                        door_d   = 1'b1;
                        dcnt_d   = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DOOR: begin
                if (dcnt_q == D_LAST) begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                moving_d = 1'b0;
                door_d   = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any trip and parks the car at floor 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= 1'b1;
            pos_q      <= 2'd0;
            gidx_q     <= 2'd0;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            cur_lbl_q  <= labelF1;
            goal_lbl_q <= labelF1;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            gidx_q     <= gidx_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            moving_q   <= moving_d;
            door_q     <= door_d;
            cur_lbl_q  <= cur_lbl_d;
            goal_lbl_q <= goal_lbl_d;
        end
    end

    assign moving        = moving_q;
    assign door_open     = door_q;
    assign current_floor = cur_lbl_q;
    assign goal_floor    = goal_lbl_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_elevator_controller
// Description : Scoreboard bench for elevator_controller. Stimulus queues the
//               expected arrival of each trip, and a negedge monitor checks
//               every door opening against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_controller;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req   = 3'b000;
    logic       moving;
    logic       door_open;
    logic [1:0] goal_floor;
    logic [1:0] current_floor;

    elevator_controller #(
        .labelF1      (2'b00),
        .labelF2      (2'b01),
        .labelF3      (2'b10),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .moving       (moving),
        .goal_floor   (goal_floor),
        .current_floor(current_floor),
        .door_open    (door_open)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] goal;
        int         moves;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push(input logic [1:0] g, input int m);
        exp_t e;
        e.goal  = g;
        e.moves = m;
        exp_q.push_back(e);
    endtask

    // Monitor: invariants every cycle, trip results on each door opening.
    logic       prev_mov = 1'b0;
    logic       prev_door = 1'b0;
    logic       in_trip = 1'b0;
    logic [1:0] glatch = 2'b00;
    int         mcnt = 0;
    int         dcnt = 0;
    exp_t       e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mov  = 1'b0;
            prev_door = 1'b0;
            in_trip   = 1'b0;
            mcnt      = 0;
            dcnt      = 0;
        end else begin
            check("moving_and_door", int'(moving & door_open), 0);
            check("cur_floor_legal", int'(current_floor == 2'b11), 0);
            check("goal_floor_legal", int'(goal_floor == 2'b11), 0);
            if (moving) begin
                if (!prev_mov) begin
                    mcnt    = 1;
                    glatch  = goal_floor;
                    in_trip = 1'b1;
                end else begin
                    mcnt++;
                end
            end
            if (in_trip)
                check("goal_hold", int'(goal_floor), int'(glatch));
            if (door_open && !prev_door) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL arrival_unexpected: got goal %0d, expected no trip", goal_floor);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("arrival_goal", int'(goal_floor), int'(e_mon.goal));
                    check("arrival_floor", int'(current_floor), int'(e_mon.goal));
                    check("move_cycles", mcnt, e_mon.moves);
                end
                dcnt = 1;
            end else if (door_open) begin
                dcnt++;
            end
            if (!door_open && prev_door) begin
                check("door_cycles", dcnt, 3);
                in_trip = 1'b0;
            end
            prev_mov  = moving;
            prev_door = door_open;
        end
    end

    // Wait for the door to open, update requests as the button block would,
    // then wait for the door to close.
    task automatic wait_arrival(input logic [2:0] clr, input logic [2:0] setm);
        int n;
        n = 0;
        while (door_open !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("arrival_timeout", 0, 1);
        req = (req & ~clr) | setm;
        n = 0;
        while (door_open !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("door_close_timeout", 0, 1);
    endtask

    initial begin
        int n;
        // Asynchronous reset takes effect without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_moving", int'(moving), 0);
        check("rst_door", int'(door_open), 0);
        check("rst_cur", int'(current_floor), 0);
        check("rst_goal", int'(goal_floor), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Floor 1 -> floor 3: moving at n+1, floor 2 reached four edges later.
        @(negedge clk);
        push(2'b10, 8);
        req = 3'b100;
        @(posedge clk);
        #1;
        check("start_latency", int'(moving), 1);
        check("start_goal", int'(goal_floor), 2);
        repeat (4) @(posedge clk);
        #1;
        check("mid_floor", int'(current_floor), 1);
        wait_arrival(3'b100, 3'b000);

        // Floor 3, dir up, only floor 1 pending: reverse and travel down.
        @(negedge clk);
        push(2'b00, 8);
        req = 3'b001;
        wait_arrival(3'b001, 3'b000);

        // Floor 1, dir down, floor 2 pending: reverse to up.
        @(negedge clk);
        push(2'b01, 4);
        req = 3'b010;
        wait_arrival(3'b010, 3'b000);

        // Floor 2, dir up, floors 1 and 3 pending: floor 3 first, then floor 1.
        @(negedge clk);
        push(2'b10, 4);
        push(2'b00, 8);
        req = 3'b101;
        wait_arrival(3'b100, 3'b000);
        wait_arrival(3'b001, 3'b000);

        // Request at the current floor: single-cycle zero-travel move.
        @(negedge clk);
        push(2'b00, 1);
        req = 3'b001;
        wait_arrival(3'b001, 3'b000);

        // Floor 2 requested mid-trip to floor 3: no retarget, served next.
        // A floor-2 press during that door time gives another zero-travel trip.
        @(negedge clk);
        push(2'b10, 8);
        push(2'b01, 4);
        push(2'b01, 1);
        req = 3'b100;
        repeat (3) @(negedge clk);
        req = req | 3'b010;
        wait_arrival(3'b100, 3'b000);
        wait_arrival(3'b010, 3'b010);
        wait_arrival(3'b010, 3'b000);

        // Reset in the middle of a trip from floor 2 toward floor 3.
        @(negedge clk);
        push(2'b10, 4);
        req = 3'b100;
        n = 0;
        while (moving !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("move_start_timeout", 0, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_floor", int'(current_floor), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_moving", int'(moving), 0);
        check("async_rst_door", int'(door_open), 0);
        check("async_rst_cur", int'(current_floor), 0);
        check("async_rst_goal", int'(goal_floor), 0);
        exp_q.delete();
        @(negedge clk);
        push(2'b10, 8);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_moving", int'(moving), 1);
        check("post_rst_goal", int'(goal_floor), 2);
        check("post_rst_cur", int'(current_floor), 0);
        wait_arrival(3'b100, 3'b000);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
